// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (IF) and data (DM) requesters.
// Latency: request sampled in IDLE -> mem_req next cycle; ack one cycle after mem_ready.
// Backpressure: requesters hold req until ack; memory holds the access until mem_ready.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              grant_dm_o
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  state_t              state_q;
  logic [3:0]          streak_q;
  logic                if_ack_q;
  logic                dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                grant_dm_q;

  logic                streak_full_d;
  logic                pick_dm_d;

  // DM wins unless IF is also waiting and DM has used up its streak allowance
  always_comb begin
    streak_full_d = (streak_q == STREAK_MAX);
    pick_dm_d     = dm_req_i && !(if_req_i && streak_full_d);
  end

  // Arbitration FSM; every output is a register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_dm_q  <= 1'b0;
    end else begin
      // acks are single-cycle pulses raised only on the way into RESP
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_dm_d) begin
            state_q     <= DM_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            grant_dm_q  <= 1'b1;
            // only contended DM grants count towards the streak
            if (if_req_i && !streak_full_d) begin
              streak_q <= streak_q + 4'd1;
            end
          end else if (if_req_i) begin
            state_q     <= IF_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            grant_dm_q  <= 1'b0;
            streak_q    <= 4'd0;
          end
        end
        IF_ACC: begin
          if (mem_ready_i) begin
            state_q    <= RESP;
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata_i;
            if_ack_q   <= 1'b1;
          end
        end
        DM_ACC: begin
          if (mem_ready_i) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata_i;
            end
            dm_ack_q <= 1'b1;
          end
        end
        RESP: begin
          // requester still holds req this cycle, so no arbitration here
          state_q    <= IDLE;
          grant_dm_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign grant_dm_o  = grant_dm_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported backing memory between the instruction-fetch path and the data-memory stage of the pipeline. Each requester uses a hold-until-ack handshake. The memory side uses a hold-until-ready handshake with variable latency. Data accesses win contention, with a streak limit that guarantees fetch progress; the pipeline stalls while its request is outstanding.

## Interface
- ADDR_W, 32, address width (word addresses, matching PC increment of 1)
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, consecutive contended DM grants allowed before IF is forced; range 1..15

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction; held until the next IF completion
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  read data; updated on read completions only
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ready  in  1  memory completes the access in the cycle it is high while mem_req=1
- mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle
- grant_dm  out  1  1 while DM owns the port (DM_ACC or DM RESP)

## Operation
- State machine: IDLE, IF_ACC, DM_ACC, RESP.
- IDLE: arbitrate on the sampled if_req and dm_req.
  - dm_req only: go to DM_ACC.
  - if_req only: go to IF_ACC.
  - Both requesting: go to DM_ACC unless streak == MAX_DM_STREAK, in which case go to IF_ACC.
  - Neither requesting: stay in IDLE.
- On entering either ACC state, load mem_req=1 and copy the winner's we/addr/wdata into the mem_* registers. IF always loads mem_we=0 and mem_wdata=0.
- IF_ACC / DM_ACC: hold mem_* constant. On mem_ready=1:
  - clear mem_req;
  - capture mem_rdata into if_rdata (IF) or dm_rdata (DM read only);
  - go to RESP and pulse the owner's ack in the RESP cycle.
- RESP: ack high for exactly this cycle, then go to IDLE. No arbitration happens in RESP, because the requester's req is still high in this cycle.
- Streak counter, 4 bits:
  - a DM grant in IDLE while if_req=1 increments it, saturating at MAX_DM_STREAK;
  - a DM grant with if_req=0 leaves it unchanged;
  - any IF grant clears it to 0.
- mem_ready while in IDLE or RESP is ignored.
- A requester that drops req while its access is in flight is not supported; the access completes and still acks.
- Reset assertion at any time forces state IDLE and clears streak and all outputs. An in-flight memory request is abandoned, and the memory must tolerate mem_req falling without mem_ready.

## Timing
- Reset values: if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, grant_dm=0.
- The request is sampled in IDLE at edge E. mem_req is high from E. If mem_ready is high in memory cycle k (k>=1 cycles after E), the ack is high in the following cycle.
- Minimum latency: req high in cycle 0 gives mem_req in cycle 1; mem_ready in cycle 1 gives ack in cycle 2; IDLE is reached in cycle 3.
- Maximum throughput is one access per 3 cycles with zero-wait memory.
- Ack and rdata update at the same edge, and rdata stays stable afterward.
- No combinational path from any input to any output.

## Test plan
- Zero-wait IF read: if_req=1, if_addr=0x10, memory returns 0x8C220004 with mem_ready tied high -> mem_addr=0x10 and mem_we=0 in cycle 1; if_ack pulse in cycle 2 with if_rdata=0x8C220004; IDLE in cycle 3.
- DM write with 3 wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_req high for 4 cycles with stable fields; dm_ack 1 cycle after mem_ready; dm_rdata unchanged.
- Contention with MAX_DM_STREAK=4: if_req and dm_req held continuously, acked and re-raised each time -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; grant_dm tracks DM ownership.
- Streak untouched without contention: 6 lone DM accesses, then both request -> the DM access wins because streak stays 0.
- Stray mem_ready in IDLE and RESP -> no ack and no rdata change.
- Reset mid-access: assert reset 2 cycles into a 5-wait-state DM read -> all outputs 0 asynchronously; after release with dm_req still high, a fresh access starts and acks normally with the new data.
